spi_adc_rx: RTL and testbench
=============================

# spi_adc_rx

Serial-in capture block for the 12-bit SPI ADC channel: on a `start` request it asserts `cs`, generates 16 `sclk` periods and shifts in one ADC frame. The frame is 4 leading zero bits followed by 12 data bits, MSB first. It returns the sample on a parallel bus with a one-cycle `valid` strobe. It sits beside the DAC serialiser on the same `clk_in` domain and feeds the sample-processing datapath.

## Interface
- `SCLK_DIV`, default 2: `sclk` half-period in `clk_in` cycles; legal range 1..255.
- `clk_in  in  1` — system clock; all logic on rising edge.
- `rst  in  1` — synchronous, active-high reset.
- `start  in  1` — conversion request; sampled only in IDLE.
- `sdata  in  1` — serial data from ADC; ADC changes it after `sclk` falls.
- `cs  out  1` — chip select, active low, registered.
- `sclk  out  1` — serial clock, idles high (CPOL=1), registered.
- `dout  out  12` — last captured sample; holds until the next `valid`.
- `valid  out  1` — one-cycle strobe; `dout` (and `err`) are updated in the same cycle.
- `busy  out  1` — high in every state except IDLE.
- `err  out  1` — leading-zero violation flag for the last frame (see Configuration).

## Operation
- States: IDLE → SETUP → SHIFT → DONE → QUIET → IDLE.
- IDLE:
  - `cs`=1, `sclk`=1, `busy`=0.
  - `start`=1 moves to SETUP on the next edge.
- SETUP: `cs`=0, `sclk`=1 for SCLK_DIV cycles. This gives the ADC its CS-to-first-edge setup time.
- SHIFT:
  - 16 bit periods, each = `sclk` low for SCLK_DIV cycles, then `sclk` high for SCLK_DIV cycles.
  - `sdata` is registered on the `clk_in` edge at which `sclk` goes 0→1.
  - The 16-bit shift register shifts left, LSB-in. The 4-bit bit counter counts 0..15.
  - After the high phase of bit 15, go to DONE.
- DONE (1 cycle):
  - `cs`=1, `valid`=1.
  - `dout` ← shift[11:0]; `err` updated.
- QUIET: `cs`=1, `sclk`=1 for 2×SCLK_DIV cycles (ADC quiet time), then IDLE.
- `start` outside IDLE is ignored. It is not queued.
- Half-period counter: 8 bits, reloads at every phase boundary. No wrap beyond SCLK_DIV−1.
- Reset mid-frame aborts the frame immediately:
  - `cs`=1, `sclk`=1, no `valid` is issued.
  - The next `start` begins a fresh frame.
- `start` held high continuously produces back-to-back frames, one per frame period.

## Timing
- Reset values:
  - `cs`=1, `sclk`=1, `dout`=12'h000, `valid`=0, `busy`=0, `err`=0.
  - State = IDLE, counters = 0, shift register = 0.
- With `start` high at edge 0 (in IDLE):
  - `cs` falls at cycle 1.
  - First `sclk` fall at cycle 1+SCLK_DIV.
  - Bit k is sampled at the end of cycle SCLK_DIV+2·SCLK_DIV·k+SCLK_DIV.
  - `valid`/`cs` rise at cycle 1+33·SCLK_DIV.
  - IDLE (`busy`=0) at cycle 2+35·SCLK_DIV.
- SCLK_DIV=2 figures:
  - `valid` at cycle 67.
  - IDLE at cycle 72.
  - Minimum frame period 72 cycles.
- `sclk` frequency = f(`clk_in`)/(2·SCLK_DIV). `sclk` duty cycle is exactly 50% during SHIFT.
- `dout` and `err` are stable from the `valid` cycle until the next `valid`.

## Configuration
- Macro: `SPI_ADC_RX_ZERO_CHECK_EN`.
- Defined:
  - In DONE, `err` ← OR of shift[15:12].
  - `err` is set on any non-zero leading bit and cleared by a clean frame.
  - `dout` is still updated on error.
- Undefined:
  - `err` is tied 0.
  - Leading bits are shifted in and discarded with no check.
  - The port remains present so instantiations are unchanged.

## Test plan
- Reset, then ADC model sends 0x0ABC with SCLK_DIV=2, `start` pulsed 1 cycle → `cs` low cycles 1..66, exactly 16 `sclk` falls, `valid` at cycle 67 with `dout`=12'hABC, `err`=0, `busy` low at 72.
- SCLK_DIV=1, frames 0x0FFF then 0x0000 with `start` held high → `dout`=12'hFFF then 12'h000, consecutive `valid`s 37 cycles apart, `cs` high ≥2 cycles between frames.
- `rst` asserted during bit 7 of SHIFT → next cycle `cs`=1, `sclk`=1, `busy`=0, no `valid`; following `start` with 0x0555 → `dout`=12'h555.
- With `SPI_ADC_RX_ZERO_CHECK_EN`, frame 0x8123 → `valid` with `dout`=12'h123, `err`=1; next frame 0x0123 → `err`=0. Without the macro, same stimulus → `err`=0 throughout.
- `start` pulsed during SHIFT and during QUIET → ignored: exactly one frame and one `valid`, and `cs` never falls until IDLE is reached.

Source files
------------

// File: rtl/spi_adc_rx.sv
// SPI capture for the 12-bit ADC: drives cs/sclk (CPOL=1) and shifts in a 16-bit frame MSB first.
// Optional leading-zero check enabled by defining SPI_ADC_RX_ZERO_CHECK_EN.
module spi_adc_rx #(
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic        sdata,
    output logic        cs,
    output logic        sclk,
    output logic [11:0] dout,
    output logic        valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;

    localparam logic [7:0] HALF_LAST = 8'(SCLK_DIV - 1);

    state_t      state, state_next;
    logic [7:0]  half_cnt, half_cnt_next;
    logic [3:0]  bit_cnt, bit_cnt_next;
    logic        phase, phase_next;
    logic        half_done;
    logic        sample;
    logic [15:0] shift_reg;

    assign half_done = (half_cnt == HALF_LAST);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            half_cnt <= 8'd0;
            bit_cnt  <= 4'd0;
            phase    <= 1'b0;
        end else begin
            state    <= state_next;
            half_cnt <= half_cnt_next;
            bit_cnt  <= bit_cnt_next;
            phase    <= phase_next;
        end
    end

    // phase selects the half of a bit period in SHIFT (0 = sclk low) and of the quiet time in QUIET
    always_comb begin
        state_next    = state;
        half_cnt_next = half_cnt;
        bit_cnt_next  = bit_cnt;
        phase_next    = phase;
        sample        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = SETUP;
                    half_cnt_next = 8'd0;
                end
            end
            SETUP: begin
                if (half_done) begin
                    state_next    = SHIFT;
                    half_cnt_next = 8'd0;
                    bit_cnt_next  = 4'd0;
                    phase_next    = 1'b0;
                end else begin
                    half_cnt_next = half_cnt + 8'd1;
                end
            end
            SHIFT: begin
                if (half_done) begin
                    half_cnt_next = 8'd0;
                    if (!phase) begin
                        phase_next = 1'b1;
                        sample     = 1'b1;
                    end else if (bit_cnt == 4'd15) begin
                        state_next = DONE;
                        phase_next = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                        phase_next   = 1'b0;
                    end
                end else begin
                    half_cnt_next = half_cnt + 8'd1;
                end
            end
            DONE: begin
                state_next    = QUIET;
                half_cnt_next = 8'd0;
                phase_next    = 1'b0;
            end
            QUIET: begin
                if (half_done) begin
                    half_cnt_next = 8'd0;
                    if (phase) begin
                        state_next = IDLE;
                        phase_next = 1'b0;
                    end else begin
                        phase_next = 1'b1;
                    end
                end else begin
                    half_cnt_next = half_cnt + 8'd1;
                end
            end
            default: begin
                state_next    = IDLE;
                half_cnt_next = 8'd0;
                bit_cnt_next  = 4'd0;
                phase_next    = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cs        <= 1'b1;
            sclk      <= 1'b1;
            valid     <= 1'b0;
            busy      <= 1'b0;
            dout      <= 12'h000;
            shift_reg <= 16'h0000;
        end else begin
            cs    <= !(state_next == SETUP || state_next == SHIFT);
            sclk  <= !(state_next == SHIFT && !phase_next);
            valid <= (state_next == DONE);
            busy  <= (state_next != IDLE);
            if (sample)
                shift_reg <= {shift_reg[14:0], sdata};
            if (state_next == DONE)
                dout <= shift_reg[11:0];
        end
    end

`ifdef SPI_ADC_RX_ZERO_CHECK_EN
    always_ff @(posedge clk_in) begin
        if (rst)
            err <= 1'b0;
        else if (state_next == DONE)
            err <= |shift_reg[15:12];
    end
`else
    logic unused_lead;
    assign unused_lead = |shift_reg[15:12];
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_adc_rx.sv
// Self-checking bench for spi_adc_rx: two instances (SCLK_DIV=2 and 1), an ADC model per instance
// and a scoreboard of expected {err, dout} popped on each valid strobe.
module tb_spi_adc_rx;

    localparam int CLK_HALF = 5;

`ifdef SPI_ADC_RX_ZERO_CHECK_EN
    localparam logic ZC = 1'b1;
`else
    localparam logic ZC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start2 = 1'b0, start1 = 1'b0;
    logic        sdata2 = 1'b0, sdata1 = 1'b0;
    logic        cs2, sclk2, valid2, busy2, err2;
    logic        cs1, sclk1, valid1, busy1, err1;
    logic [11:0] dout2, dout1;

    always #CLK_HALF clk = ~clk;

    spi_adc_rx #(.SCLK_DIV(2)) dut2 (
        .clk_in(clk), .rst(rst), .start(start2), .sdata(sdata2),
        .cs(cs2), .sclk(sclk2), .dout(dout2), .valid(valid2), .busy(busy2), .err(err2)
    );

    spi_adc_rx #(.SCLK_DIV(1)) dut1 (
        .clk_in(clk), .rst(rst), .start(start1), .sdata(sdata1),
        .cs(cs1), .sclk(sclk1), .dout(dout1), .valid(valid1), .busy(busy1), .err(err1)
    );

    int total = 0;
    int bad = 0;

    logic [15:0] adc_q2[$], adc_q1[$];
    logic [12:0] exp_q2[$], exp_q1[$];
    logic [15:0] adc_sr2 = 16'h0, adc_sr1 = 16'h0;
    int cs_falls2 = 0, sclk_falls2 = 0, valid_cnt2 = 0, valid_cnt1 = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push2(input logic [15:0] w);
        adc_q2.push_back(w);
        exp_q2.push_back({ZC & (|w[15:12]), w[11:0]});
    endtask

    task automatic push1(input logic [15:0] w);
        adc_q1.push_back(w);
        exp_q1.push_back({ZC & (|w[15:12]), w[11:0]});
    endtask

    // Pulses start2 so that it is sampled on exactly one edge (edge 0); returns just after it
    task automatic apply_stimulus;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
    endtask

    // ADC models: new word on cs fall, next bit presented after each sclk fall
    always @(negedge cs2) begin
        cs_falls2++;
        adc_sr2 = (adc_q2.size() > 0) ? adc_q2.pop_front() : 16'h0;
    end

    always @(negedge sclk2) begin
        if (cs2 === 1'b0) begin
            sdata2 = adc_sr2[15];
            adc_sr2 = {adc_sr2[14:0], 1'b0};
            sclk_falls2++;
        end
    end

    always @(negedge cs1) begin
        adc_sr1 = (adc_q1.size() > 0) ? adc_q1.pop_front() : 16'h0;
    end

    always @(negedge sclk1) begin
        if (cs1 === 1'b0) begin
            sdata1 = adc_sr1[15];
            adc_sr1 = {adc_sr1[14:0], 1'b0};
        end
    end

    // Scoreboard: each valid must match the oldest outstanding expected sample
    always @(negedge clk) begin
        logic [12:0] e;
        if (rst === 1'b0 && valid2 === 1'b1) begin
            valid_cnt2++;
            if (exp_q2.size() == 0) begin
                check_output("dut2_spurious_valid", valid2, 0);
            end else begin
                e = exp_q2.pop_front();
                check_output("dut2_dout", dout2, e[11:0]);
                check_output("dut2_err", err2, e[12]);
            end
        end
        if (rst === 1'b0 && valid1 === 1'b1) begin
            valid_cnt1++;
            if (exp_q1.size() == 0) begin
                check_output("dut1_spurious_valid", valid1, 0);
            end else begin
                e = exp_q1.pop_front();
                check_output("dut1_dout", dout1, e[11:0]);
                check_output("dut1_err", err1, e[12]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v0, f0, c0;
        int cs_low_cnt, cs_first, cs_last, valid_cyc, idle_cyc;
        int va, vb, gap;
        bit seen_a, counting_gap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_cs", cs2, 1);
        check_output("reset_sclk", sclk2, 1);
        check_output("reset_dout", dout2, 12'h000);
        check_output("reset_valid", valid2, 0);
        check_output("reset_busy", busy2, 0);
        check_output("reset_err", err2, 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_output("idle_busy", busy2, 0);

        // Single frame 0x0ABC, SCLK_DIV=2: cycle-accurate framing
        push2(16'h0ABC);
        v0 = valid_cnt2;
        f0 = sclk_falls2;
        apply_stimulus();
        cs_low_cnt = 0; cs_first = 0; cs_last = 0; valid_cyc = 0; idle_cyc = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (cs2 === 1'b0) begin
                cs_low_cnt++;
                if (cs_first == 0) cs_first = c;
                cs_last = c;
            end
            if (valid2 === 1'b1 && valid_cyc == 0) valid_cyc = c;
            if (busy2 === 1'b0 && idle_cyc == 0) idle_cyc = c;
        end
        check_output("f1_cs_low_cycles", cs_low_cnt, 66);
        check_output("f1_cs_first_low", cs_first, 1);
        check_output("f1_cs_last_low", cs_last, 66);
        check_output("f1_valid_cycle", valid_cyc, 67);
        check_output("f1_idle_cycle", idle_cyc, 72);
        check_output("f1_sclk_falls", sclk_falls2 - f0, 16);
        check_output("f1_valid_count", valid_cnt2 - v0, 1);

        // Back-to-back frames with start held, SCLK_DIV=1
        push1(16'h0FFF);
        push1(16'h0000);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        va = 0; vb = 0; gap = 0; seen_a = 0; counting_gap = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (counting_gap) begin
                if (cs1 === 1'b1) gap++;
                else counting_gap = 0;
            end
            if (valid1 === 1'b1) begin
                if (!seen_a) begin
                    va = c; seen_a = 1; counting_gap = 1; gap = 1;
                end else if (vb == 0) begin
                    vb = c; start1 = 1'b0;
                end
            end
        end
        start1 = 1'b0;
        check_output("b2b_first_valid", va, 34);
        check_output("b2b_valid_spacing", vb - va, 37);
        check_output("b2b_cs_gap_ge2", (gap >= 2), 1);
        check_output("b2b_valid_count", valid_cnt1, 2);
        check_output("b2b_idle", busy1, 0);

        // Reset during bit 7 aborts the frame; a fresh frame then succeeds
        adc_q2.push_back(16'h0AAA);
        v0 = valid_cnt2;
        apply_stimulus();
        repeat (31) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("abort_cs", cs2, 1);
        check_output("abort_sclk", sclk2, 1);
        check_output("abort_busy", busy2, 0);
        check_output("abort_valid", valid2, 0);
        repeat (20) @(negedge clk);
        check_output("abort_no_valid", valid_cnt2 - v0, 0);
        push2(16'h0555);
        apply_stimulus();
        valid_cyc = 0;
        for (int c = 1; c <= 100 && valid_cyc == 0; c++) begin
            @(negedge clk);
            if (valid2 === 1'b1) valid_cyc = c;
        end
        check_output("after_abort_valid_cycle", valid_cyc, 67);
        repeat (10) @(negedge clk);

        // Leading-zero check: 0x8123 then 0x0123
        push2(16'h8123);
        apply_stimulus();
        repeat (80) @(negedge clk);
        check_output("lz_dout_8123", dout2, 12'h123);
        check_output("lz_err_8123", err2, ZC);
        push2(16'h0123);
        apply_stimulus();
        repeat (80) @(negedge clk);
        check_output("lz_dout_0123", dout2, 12'h123);
        check_output("lz_err_0123", err2, 0);

        // start pulses during SHIFT (edge 20) and QUIET (edge 69) are ignored
        push2(16'h0246);
        v0 = valid_cnt2;
        c0 = cs_falls2;
        apply_stimulus();
        repeat (19) @(posedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        repeat (48) @(posedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        repeat (40) @(negedge clk);
        check_output("ignore_cs_falls", cs_falls2 - c0, 1);
        check_output("ignore_valid_count", valid_cnt2 - v0, 1);
        check_output("ignore_idle", busy2, 0);
        check_output("ignore_cs_high", cs2, 1);

        check_output("sb_empty_dut2", exp_q2.size(), 0);
        check_output("sb_empty_dut1", exp_q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
